// File: rtl/ahb2apb_pkg.sv
// ---------------------------------------------------------------------------
// ahb2apb_pkg
//  Shared types and helpers for the AHB-Lite to APB4 bridge.
//   htrans_t        AHB transfer type encoding
//   bridge_state_t  bridge FSM states
//   HRESP_*         AHB response encodings
//   size_legal()    1 when an HSIZE beat fits the data bus
// ---------------------------------------------------------------------------
package ahb2apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } bridge_state_t;

    // A beat of 8<<hsize bits must not exceed the bus width.
    function automatic logic size_legal(input logic [2:0] hsize, input int data_width);
        return (32'd8 << hsize) <= data_width;
    endfunction

endpackage

// File: rtl/ahb2apb_pstrb_gen.sv
// ---------------------------------------------------------------------------
// ahb2apb_pstrb_gen
//  Combinational APB write-strobe generator. Output is registered by parent.
//  Macro AHB2APB_PSTRB_EN:
//   defined   : write strobe = size mask shifted by the address byte lane
//   undefined : write strobe = all ones
//  Reads always produce a zero strobe.
// Ports
//  i_hsize     in   3       AHB transfer size
//  i_addr_lsb  in   LSB_W   byte-lane bits of HADDR
//  i_write     in   1       1 = write transfer
//  o_pstrb     out  STRB_W  byte strobes
// ---------------------------------------------------------------------------
module ahb2apb_pstrb_gen #(
    parameter int STRB_W = 4,
    parameter int LSB_W  = 2
) (
    input  logic [2:0]        i_hsize,
    input  logic [LSB_W-1:0]  i_addr_lsb,
    input  logic              i_write,
    output logic [STRB_W-1:0] o_pstrb
);

`ifdef AHB2APB_PSTRB_EN
    logic [STRB_W-1:0] w_mask;

    // Lower (1<<hsize) lanes set; equivalent to (1<<(1<<hsize))-1.
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            if (b < (1 << i_hsize)) w_mask[b] = 1'b1;
        end
    end

    assign o_pstrb = i_write ? (w_mask << i_addr_lsb) : '0;
`else
    logic w_unused_ok;
    assign w_unused_ok = ^{i_hsize, i_addr_lsb};
    assign o_pstrb     = i_write ? '1 : '0;
`endif

endmodule

// File: rtl/ahb2apb_bridge_mslv.sv
// ---------------------------------------------------------------------------
// ahb2apb_bridge_mslv
//  AHB-Lite slave to APB4 master bridge, single clock, NUM_SLAVES peripherals.
//  Slave index = HADDR[SLV_SEL_LSB +: SEL_W]; out-of-range index or oversize
//  HSIZE gives a two-cycle AHB ERROR without touching APB.
//  Optional macro AHB2APB_PSTRB_EN enables size/lane based PSTRB.
// Ports
//  HCLK, HRESETn                      clock, async active-low reset
//  HSEL/HADDR/HTRANS/HWRITE/HSIZE     AHB address phase
//  HWDATA, HREADYIN                   AHB data phase / bus ready
//  HRDATA/HREADYOUT/HRESP             AHB response (all registered)
//  PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB  APB request (all registered)
//  PRDATA/PREADY/PSLVERR              per-slave APB response
// ---------------------------------------------------------------------------
module ahb2apb_bridge_mslv
    import ahb2apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SLAVES  = 4,
    parameter int SLV_SEL_LSB = 12
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic                            HSEL,
    input  logic [ADDR_WIDTH-1:0]           HADDR,
    input  logic [1:0]                      HTRANS,
    input  logic                            HWRITE,
    input  logic [2:0]                      HSIZE,
    input  logic [DATA_WIDTH-1:0]           HWDATA,
    input  logic                            HREADYIN,
    output logic [DATA_WIDTH-1:0]           HRDATA,
    output logic                            HREADYOUT,
    output logic                            HRESP,
    output logic [ADDR_WIDTH-1:0]           PADDR,
    output logic [NUM_SLAVES-1:0]           PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [DATA_WIDTH-1:0]           PWDATA,
    output logic [DATA_WIDTH/8-1:0]         PSTRB,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]           PREADY,
    input  logic [NUM_SLAVES-1:0]           PSLVERR
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int LSB_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;

    bridge_state_t          r_state;
    logic [SEL_W-1:0]       r_idx;

    htrans_t                w_htrans;
    logic                   w_valid;
    logic [SEL_W-1:0]       w_idx;
    logic                   w_idx_ok;
    logic                   w_size_ok;
    logic [STRB_W-1:0]      w_pstrb;
    logic [DATA_WIDTH-1:0]  w_prdata;
    logic                   w_pready;
    logic                   w_pslverr;

    assign w_htrans  = htrans_t'(HTRANS);
    assign w_valid   = HSEL & HREADYIN &
                       ((w_htrans == HTRANS_NONSEQ) || (w_htrans == HTRANS_SEQ));
    assign w_idx     = HADDR[SLV_SEL_LSB +: SEL_W];
    assign w_idx_ok  = (int'(w_idx) < NUM_SLAVES);
    assign w_size_ok = size_legal(HSIZE, DATA_WIDTH);

    ahb2apb_pstrb_gen #(
        .STRB_W (STRB_W),
        .LSB_W  (LSB_W)
    ) u_pstrb_gen (
        .i_hsize    (HSIZE),
        .i_addr_lsb (HADDR[LSB_W-1:0]),
        .i_write    (HWRITE),
        .o_pstrb    (w_pstrb)
    );

    // Only the latched slave's response is looked at.
    always_comb begin
        w_prdata  = '0;
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == SEL_W'(i)) begin
                w_prdata  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
                w_pready  = PREADY[i];
                w_pslverr = PSLVERR[i];
            end
        end
    end

    // Outputs are set on state entry so they read as the state's values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            HRDATA    <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            PADDR     <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                    if (w_valid) begin
                        HREADYOUT <= 1'b0;
                        if (w_idx_ok && w_size_ok) begin
                            PADDR  <= HADDR;
                            PWRITE <= HWRITE;
                            PSTRB  <= w_pstrb;
                            r_idx  <= w_idx;
                            if (HWRITE) begin
                                r_state <= ST_WDATA;
                            end else begin
                                PSEL    <= NUM_SLAVES'(1) << w_idx;
                                r_state <= ST_SETUP;
                            end
                        end else begin
                            HRESP   <= HRESP_ERROR;
                            r_state <= ST_ERR1;
                        end
                    end
                end
                ST_WDATA: begin
                    PWDATA  <= HWDATA;
                    PSEL    <= NUM_SLAVES'(1) << r_idx;
                    r_state <= ST_SETUP;
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_pready) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        if (w_pslverr) begin
                            HRESP   <= HRESP_ERROR;
                            r_state <= ST_ERR1;
                        end else begin
                            HREADYOUT <= 1'b1;
                            if (!PWRITE) HRDATA <= w_prdata;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_ERR1: begin
                    HRESP     <= HRESP_ERROR;
                    HREADYOUT <= 1'b1;
                    r_state   <= ST_ERR2;
                end
                ST_ERR2: begin
                    HRESP     <= HRESP_OKAY;
                    HREADYOUT <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    HRESP     <= HRESP_OKAY;
                    HREADYOUT <= 1'b1;
                    PSEL      <= '0;
                    PENABLE   <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge_mslv.sv
// ---------------------------------------------------------------------------
// tb_ahb2apb_bridge_mslv
//  Directed plus randomized transactions on a 3-slave bridge. Expected values
//  come from a transaction-level model: decode rules, latency formula,
//  expected strobe and the last read data seen on the AHB side.
// ---------------------------------------------------------------------------
module tb_ahb2apb_bridge_mslv;

    localparam int NS = 3;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic           HCLK = 1'b0;
    logic           HRESETn;
    logic           HSEL;
    logic [31:0]    HADDR;
    logic [1:0]     HTRANS;
    logic           HWRITE;
    logic [2:0]     HSIZE;
    logic [31:0]    HWDATA;
    logic           HREADYIN;
    logic [31:0]    HRDATA;
    logic           HREADYOUT;
    logic           HRESP;
    logic [31:0]    PADDR;
    logic [NS-1:0]  PSEL;
    logic           PENABLE;
    logic           PWRITE;
    logic [31:0]    PWDATA;
    logic [3:0]     PSTRB;
    logic [NS*32-1:0] PRDATA;
    logic [NS-1:0]  PREADY;
    logic [NS-1:0]  PSLVERR;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_hrdata;

    always #5 HCLK = ~HCLK;

    ahb2apb_bridge_mslv #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .NUM_SLAVES  (NS),
        .SLV_SEL_LSB (12)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADYIN  (HREADYIN),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // One bus cycle that must not start a transfer.
    task automatic idle_cycle(input logic sel, input logic [1:0] trans, input logic rdyin);
        HSEL = sel; HTRANS = trans; HREADYIN = rdyin;
        HADDR = 32'h0000_1000; HWRITE = 1'b0; HSIZE = 3'd2;
        step();
        HSEL = 1'b0; HTRANS = T_IDLE; HREADYIN = 1'b1;
        chk("idle_rdy",  HREADYOUT, 1);
        chk("idle_resp", HRESP, 0);
        chk("idle_psel", PSEL, 0);
        chk("idle_pen",  PENABLE, 0);
    endtask

    // Full transaction starting in a cycle where HREADYOUT is high; returns in
    // the first cycle the bridge can take another address.
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int waits, input logic slverr, input logic [1:0] trans);
        int            idx, cyc, acc, t_setup, t_end, strb_i;
        bit            legal;
        logic [3:0]    exp_strb;
        logic [NS-1:0] oh;
        idx   = int'(addr[13:12]);
        legal = (idx < NS) && ((8 << size) <= 32);
        oh    = '0;
        if (legal) oh[idx] = 1'b1;
`ifdef AHB2APB_PSTRB_EN
        strb_i = ((1 << (1 << size)) - 1) << addr[1:0];
`else
        strb_i = 15;
`endif
        exp_strb = wr ? strb_i[3:0] : 4'h0;
        for (int i = 0; i < NS; i++)
            PRDATA[i*32 +: 32] = (i == idx) ? rdata : $urandom;

        HSEL = 1'b1; HADDR = addr; HTRANS = trans; HWRITE = wr; HSIZE = size;
        chk("addr_rdy", HREADYOUT, 1);
        step();
        HSEL = 1'b0; HTRANS = T_IDLE; HADDR = $urandom; HWRITE = 1'($urandom);
        HSIZE = 3'($urandom); HWDATA = wdata;

        if (!legal) begin
            chk("derr1_rdy",  HREADYOUT, 0);
            chk("derr1_resp", HRESP, 1);
            chk("derr1_psel", PSEL, 0);
            step();
            chk("derr2_rdy",  HREADYOUT, 1);
            chk("derr2_resp", HRESP, 1);
            chk("derr2_psel", PSEL, 0);
            step();
            chk("derr_end_rdy",  HREADYOUT, 1);
            chk("derr_end_resp", HRESP, 0);
            chk("derr_hrdata",   HRDATA, m_hrdata);
            return;
        end

        t_setup = wr ? 2 : 1;
        t_end   = t_setup + 2 + waits;
        cyc = 1; acc = 0;
        while (cyc < 40 && !(HREADYOUT || HRESP)) begin
            // Non-selected slaves shout ready+error; they must be ignored.
            PREADY = ~oh; PSLVERR = ~oh;
            if (cyc == 2) HWDATA = $urandom;
            if (cyc < t_setup) begin
                chk("wdata_psel", PSEL, 0);
            end else if (cyc == t_setup) begin
                chk("setup_psel", PSEL, oh);
                chk("setup_pen",  PENABLE, 0);
            end else begin
                chk("acc_psel",   PSEL, oh);
                chk("acc_pen",    PENABLE, 1);
                chk("acc_paddr",  PADDR, addr);
                chk("acc_pwrite", PWRITE, wr);
                chk("acc_pstrb",  PSTRB, exp_strb);
                if (wr) chk("acc_pwdata", PWDATA, wdata);
                PREADY[idx]  = (acc == waits);
                PSLVERR[idx] = (acc == waits) ? slverr : 1'($urandom);
                acc++;
            end
            step();
            cyc++;
        end
        PREADY = '0; PSLVERR = '0;
        chk("latency", cyc, t_end);

        if (slverr) begin
            chk("serr1_rdy",  HREADYOUT, 0);
            chk("serr1_resp", HRESP, 1);
            chk("serr1_psel", PSEL, 0);
            chk("serr1_pen",  PENABLE, 0);
            step();
            chk("serr2_rdy",  HREADYOUT, 1);
            chk("serr2_resp", HRESP, 1);
            step();
            chk("serr_end_rdy",  HREADYOUT, 1);
            chk("serr_end_resp", HRESP, 0);
        end else begin
            if (!wr) m_hrdata = rdata;
            chk("done_rdy",  HREADYOUT, 1);
            chk("done_resp", HRESP, 0);
            chk("done_psel", PSEL, 0);
            chk("done_pen",  PENABLE, 0);
        end
        chk("hrdata", HRDATA, m_hrdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        int          r;

        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = T_IDLE; HWRITE = 1'b0;
        HSIZE = 3'd0; HWDATA = '0; HREADYIN = 1'b1;
        PRDATA = '0; PREADY = '0; PSLVERR = '0;
        m_hrdata = '0;

        // Reset state
        step(); step();
        chk("rst_rdy",    HREADYOUT, 1);
        chk("rst_resp",   HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_psel",   PSEL, 0);
        chk("rst_pen",    PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr",  PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_pstrb",  PSTRB, 0);
        HRESETn = 1'b1;
        step();
        chk("post_rst_rdy", HREADYOUT, 1);

        // 1: read slave 2, zero wait
        run_txn(32'h0000_2004, 1'b0, 3'd2, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, T_NONSEQ);
        // 2: halfword write slave 1, three wait states
        run_txn(32'h0000_1002, 1'b1, 3'd1, 32'h1234_0000, 32'h0, 3, 1'b0, T_NONSEQ);
        // 3: write slave 0 with slave error
        run_txn(32'h0000_0010, 1'b1, 3'd2, 32'hCAFE_0001, 32'h0, 0, 1'b1, T_NONSEQ);
        // 4: out-of-range slave and oversize beat
        run_txn(32'h0000_3000, 1'b0, 3'd2, 32'h0, 32'h5555_AAAA, 0, 1'b0, T_NONSEQ);
        run_txn(32'h0000_1000, 1'b0, 3'd3, 32'h0, 32'h5555_AAAA, 0, 1'b0, T_NONSEQ);
        // 5: back-to-back read then write, then non-transfers
        run_txn(32'h0000_0020, 1'b0, 3'd2, 32'h0, 32'h0BAD_F00D, 1, 1'b0, T_NONSEQ);
        run_txn(32'h0000_0024, 1'b1, 3'd0, 32'h0000_00A5, 32'h0, 0, 1'b0, T_SEQ);
        idle_cycle(1'b1, T_BUSY, 1'b1);
        idle_cycle(1'b0, T_NONSEQ, 1'b1);
        idle_cycle(1'b1, T_NONSEQ, 1'b0);
        run_txn(32'h0000_2028, 1'b0, 3'd2, 32'h0, 32'h7777_1111, 2, 1'b0, T_SEQ);

        // 6: reset during ACCESS
        HSEL = 1'b1; HADDR = 32'h0000_2008; HTRANS = T_NONSEQ; HWRITE = 1'b0; HSIZE = 3'd2;
        step();
        HSEL = 1'b0; HTRANS = T_IDLE; PREADY = '0;
        step();
        chk("rst_mid_pen_before", PENABLE, 1);
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_mid_psel",   PSEL, 0);
        chk("rst_mid_pen",    PENABLE, 0);
        chk("rst_mid_rdy",    HREADYOUT, 1);
        chk("rst_mid_resp",   HRESP, 0);
        chk("rst_mid_hrdata", HRDATA, 0);
        m_hrdata = '0;
        step();
        HRESETn = 1'b1;
        step();
        run_txn(32'h0000_200C, 1'b0, 3'd2, 32'h0, 32'h1357_9BDF, 0, 1'b0, T_NONSEQ);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 9);
            sz = (r == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            a  = $urandom;
            a  = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 3) == 0) idle_cycle(1'b1, T_BUSY, 1'b1);
            run_txn(a, 1'($urandom), sz, $urandom, $urandom, $urandom_range(0, 3),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1) ? T_NONSEQ : T_SEQ);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
